// File: rtl/event_handshake_tx.sv
// event_handshake_tx: turns A event pulses into a four-phase REQ/ACK handshake, queuing events that arrive mid-handshake
module event_handshake_tx #(
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 4,
  parameter int MIN_HOLD = 1
) (
  input  logic             CK,
  input  logic             R,
  input  logic             A,
  input  logic             ACK,
  output logic             REQ,
  output logic             BUSY,
  output logic [CNT_W-1:0] PEND,
  output logic             OVF
);
  localparam int HW = $clog2(MIN_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD - 1);
  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;
  state_t state_q, state_d;
  logic [DEPTH-1:0] sync_q, sync_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic req_q, req_d, busy_q, busy_d, ovf_q, ovf_d;
  logic ack_s, go, hold_ok, launch;
  assign ack_s   = sync_q[DEPTH-1];
  assign go      = (pend_q != '0) | A;
  assign hold_ok = hold_q >= HOLD_MAX;
  assign REQ     = req_q;
  assign BUSY    = busy_q;
  assign PEND    = pend_q;
  assign OVF     = ovf_q;
  // ACK is only ever seen through this shift register
  always_comb sync_d = {sync_q[DEPTH-2:0], ACK};
  // handshake sequencing: each phase waits for the synchronised ACK and the minimum hold
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? REQ_HI : IDLE;
      REQ_HI:  state_d = (ack_s && hold_ok) ? REQ_LO : REQ_HI;
      REQ_LO:  state_d = (!ack_s && hold_ok) ? (go ? REQ_HI : IDLE) : REQ_LO;
      default: state_d = IDLE;
    endcase
  end
  // hold timer, pending queue and registered outputs; a launch with an empty queue consumes A directly
  always_comb begin
    launch = (state_d == REQ_HI) && (state_q != REQ_HI);
    hold_d = (state_d != state_q) ? '0 : hold_ok ? hold_q : hold_q + 1'b1;
    ovf_d  = A && (&pend_q) && !launch;
    pend_d = ovf_d ? pend_q : pend_q + CNT_W'(A) - CNT_W'(launch);
    req_d  = state_d == REQ_HI;
    busy_d = state_d != IDLE;
  end
  // state registers; reset discards any queued or in-flight events
  always_ff @(posedge CK) begin
    if (R) begin
      state_q <= IDLE;
      sync_q  <= '0;
      hold_q  <= '0;
      pend_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
